alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
- Sequences the ALU driver (input buffer, output buffer, flag registers) for one operation at a time.
- Accepts one request via valid/ready, places operand A then operand B on the internal bus, and pulses the driver's load strobes in order.
- Signals completion once the driver's output buffer and flags hold the result.
- Also performs program-counter increment (pc+1) on the datapath's forced-add path.

Parameters:
- DATA_W, 32, bus/operand width.
- OP_W, 4, ALU opcode width.
- SHIFT_W, 5, cyclic-left-shift amount width.
- CNT_W, 16, completed-operation counter width.

Ports:
- clk  input  1  global clock.
- reset  input  1  synchronous reset, active high.
- req_valid  input  1  request present.
- req_ready  output  1  sequencer can accept a request.
- req_pc_inc  input  1  1 = pc increment; req_operand_a ignored.
- req_op_code  input  OP_W  ALU opcode.
- req_shift  input  SHIFT_W  result rotate amount.
- req_carry_in  input  1  carry in.
- req_forced_add  input  1  force addition; flags are not updated.
- req_operand_a  input  DATA_W  first operand.
- req_operand_b  input  DATA_W  second operand, or pc value.
- alu_error  input  1  driver's registered error_detect.
- err_clear  input  1  leave HALT (feature only).
- bus_drive_en  output  1  sequencer owns the internal bus.
- bus_data  output  DATA_W  value driven on the bus.
- input_buffer_load  output  1  to driver.
- output_buffer_load  output  1  to driver.
- pc_update_control  output  1  to driver.
- op_code  output  OP_W  to driver.
- shift  output  SHIFT_W  to driver.
- carry_in  output  1  to driver.
- forced_add  output  1  to driver.
- done  output  1  one-cycle pulse: driver output buffer and flags are valid.
- busy  output  1  state != IDLE.
- halted  output  1  in HALT.
- op_count  output  CNT_W  completed operations.

Behaviour:
- States: IDLE, LOAD_A, EXEC, DONE, HALT.
- Accept: handshake on a clk edge with req_valid && req_ready. req_ready = 1 only in IDLE. All req_* fields are captured into internal registers at accept; later changes on req_* are ignored.
- Transitions out of IDLE on accept: req_pc_inc=0 -> LOAD_A; req_pc_inc=1 -> EXEC.
- LOAD_A: bus_drive_en=1, bus_data=captured A, input_buffer_load=1. Next state EXEC.
- EXEC: bus_drive_en=1, bus_data=captured B, output_buffer_load=1.
  - op_code, shift, carry_in and forced_add come from captured fields.
  - pc operation: pc_update_control=1 and forced_add=1, regardless of the captured forced_add.
  - Next state DONE.
- DONE: done=1; bus released. op_count increments by 1, wrapping from all-ones to 0. Next state IDLE, or HALT (see Optional Feature).
- Latency from accept edge k: normal operation done in cycle k+3; pc operation done in cycle k+2. Throughput: one operation per 4 cycles (normal) or 3 cycles (pc). A request held valid through DONE is accepted on the first IDLE cycle.
- All driver controls are decoded from registered state and captured fields. Outside LOAD_A/EXEC, all controls and bus_drive_en are 0 and bus_data is 0.
- Reset (including mid-operation):
  - Next edge: state IDLE, captured registers 0, op_count 0.
  - All outputs 0 except req_ready=1 once in IDLE.
  - An in-flight operation is dropped without a done pulse.
- req_valid while busy: no effect; req_ready stays 0.

Optional Feature:
- Macro: ALU_SEQ_ERR_HALT_EN.
- Defined:
  - In DONE, alu_error=1 sends the sequencer to HALT instead of IDLE; done still pulses and op_count still increments.
  - HALT: req_ready=0, busy=1, halted=1, all driver controls 0.
  - err_clear=1 moves HALT -> IDLE on the next edge. reset also exits HALT.
- Not defined: halted is tied 0, err_clear and alu_error are ignored, and DONE always returns to IDLE.

Test Plan:
- Reset held 2 cycles, then released -> req_ready=1; busy, done, halted, op_count=0; all driver controls 0.
- Accept at cycle k with A=5, B=7, op_code=4'h3, shift=2, carry_in=1, forced_add=0:
  - cycle k+1: input_buffer_load=1, bus_data=5.
  - cycle k+2: output_buffer_load=1, bus_data=7, op_code=3, shift=2, carry_in=1.
  - cycle k+3: done=1; then op_count=1.
- pc increment with B=32'h100:
  - cycle k+1: pc_update_control=1, forced_add=1, output_buffer_load=1, bus_data=32'h100.
  - cycle k+2: done=1; no input_buffer_load in any cycle.
- req_valid held high with changing fields -> second request accepted at the first IDLE cycle after DONE; captured values of the first request unchanged during its EXEC.
- reset asserted during EXEC -> next cycle IDLE, no done pulse, op_count unchanged at 0.
- Wrap and halt:
  - Preload via 65535 operations -> next done makes op_count=0.
  - With ALU_SEQ_ERR_HALT_EN and alu_error=1 in DONE -> halted=1 and req_ready=0 until an err_clear pulse, then IDLE.

Source files
------------

// File: rtl/alu_sequencer.sv
// ============================================================================
//  Module   : alu_sequencer
//  Purpose  : Steps the ALU driver through one operation at a time: operand A
//             into the input buffer, operand B / pc into the output buffer, a
//             done pulse and the completed-operation count.
//             Optional halt-on-error behaviour: define ALU_SEQ_ERR_HALT_EN.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_sequencer #(
    parameter int DATA_W  = 32,
    parameter int OP_W    = 4,
    parameter int SHIFT_W = 5,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_pc_inc,
    input  logic [OP_W-1:0]    req_op_code,
    input  logic [SHIFT_W-1:0] req_shift,
    input  logic               req_carry_in,
    input  logic               req_forced_add,
    input  logic [DATA_W-1:0]  req_operand_a,
    input  logic [DATA_W-1:0]  req_operand_b,
    input  logic               alu_error,
    input  logic               err_clear,
    output logic               bus_drive_en,
    output logic [DATA_W-1:0]  bus_data,
    output logic               input_buffer_load,
    output logic               output_buffer_load,
    output logic               pc_update_control,
    output logic [OP_W-1:0]    op_code,
    output logic [SHIFT_W-1:0] shift,
    output logic               carry_in,
    output logic               forced_add,
    output logic               done,
    output logic               busy,
    output logic               halted,
    output logic [CNT_W-1:0]   op_count
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_A = 3'd1,
        ST_EXEC   = 3'd2,
        ST_DONE   = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

    state_t               r_state_q,      w_state_d;
    logic                 r_pc_inc_q,     w_pc_inc_d;
    logic [OP_W-1:0]      r_op_code_q,    w_op_code_d;
    logic [SHIFT_W-1:0]   r_shift_q,      w_shift_d;
    logic                 r_carry_in_q,   w_carry_in_d;
    logic                 r_forced_add_q, w_forced_add_d;
    logic [DATA_W-1:0]    r_operand_a_q,  w_operand_a_d;
    logic [DATA_W-1:0]    r_operand_b_q,  w_operand_b_d;
    logic [CNT_W-1:0]     r_op_count_q,   w_op_count_d;

    logic                 w_accept;

    assign w_accept = req_valid && (r_state_q == ST_IDLE);

    always_comb begin
        w_state_d      = r_state_q;
        w_pc_inc_d     = r_pc_inc_q;
        w_op_code_d    = r_op_code_q;
        w_shift_d      = r_shift_q;
        w_carry_in_d   = r_carry_in_q;
        w_forced_add_d = r_forced_add_q;
        w_operand_a_d  = r_operand_a_q;
        w_operand_b_d  = r_operand_b_q;
        w_op_count_d   = r_op_count_q;
        case (r_state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    w_pc_inc_d     = req_pc_inc;
                    w_op_code_d    = req_op_code;
                    w_shift_d      = req_shift;
                    w_carry_in_d   = req_carry_in;
                    w_forced_add_d = req_forced_add;
                    w_operand_a_d  = req_operand_a;
                    w_operand_b_d  = req_operand_b;
                    // pc increment has no A operand, so skip straight to EXEC
                    w_state_d      = req_pc_inc ? ST_EXEC : ST_LOAD_A;
                end
            end
            ST_LOAD_A: w_state_d = ST_EXEC;
            ST_EXEC:   w_state_d = ST_DONE;
            ST_DONE: begin
                w_op_count_d = r_op_count_q + CNT_W'(1);
                w_state_d    = ST_IDLE;
`ifdef ALU_SEQ_ERR_HALT_EN
                if (alu_error) begin
                    w_state_d = ST_HALT;
                end
`endif
            end
            ST_HALT: begin
`ifdef ALU_SEQ_ERR_HALT_EN
                if (err_clear) begin
                    w_state_d = ST_IDLE;
                end
`else
                w_state_d = ST_IDLE;
`endif
            end
            default: w_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q      <= ST_IDLE;
            r_pc_inc_q     <= 1'b0;
            r_op_code_q    <= '0;
            r_shift_q      <= '0;
            r_carry_in_q   <= 1'b0;
            r_forced_add_q <= 1'b0;
            r_operand_a_q  <= '0;
            r_operand_b_q  <= '0;
            r_op_count_q   <= '0;
        end else begin
            r_state_q      <= w_state_d;
            r_pc_inc_q     <= w_pc_inc_d;
            r_op_code_q    <= w_op_code_d;
            r_shift_q      <= w_shift_d;
            r_carry_in_q   <= w_carry_in_d;
            r_forced_add_q <= w_forced_add_d;
            r_operand_a_q  <= w_operand_a_d;
            r_operand_b_q  <= w_operand_b_d;
            r_op_count_q   <= w_op_count_d;
        end
    end

    always_comb begin
        bus_drive_en       = 1'b0;
        bus_data           = '0;
        input_buffer_load  = 1'b0;
        output_buffer_load = 1'b0;
        pc_update_control  = 1'b0;
        op_code            = '0;
        shift              = '0;
        carry_in           = 1'b0;
        forced_add         = 1'b0;
        done               = 1'b0;
        case (r_state_q)
            ST_LOAD_A: begin
                bus_drive_en      = 1'b1;
                bus_data          = r_operand_a_q;
                input_buffer_load = 1'b1;
            end
            ST_EXEC: begin
                bus_drive_en       = 1'b1;
                bus_data           = r_operand_b_q;
                output_buffer_load = 1'b1;
                op_code            = r_op_code_q;
                shift              = r_shift_q;
                carry_in           = r_carry_in_q;
                // pc+1 rides the forced-add path whatever the request asked
                forced_add         = r_forced_add_q | r_pc_inc_q;
                pc_update_control  = r_pc_inc_q;
            end
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

    assign req_ready = (r_state_q == ST_IDLE);
    assign busy      = (r_state_q != ST_IDLE);
    assign op_count  = r_op_count_q;

`ifdef ALU_SEQ_ERR_HALT_EN
    assign halted = (r_state_q == ST_HALT);
`else
    logic w_unused_ok;
    assign w_unused_ok = alu_error ^ err_clear;
    assign halted      = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_sequencer.sv
// ============================================================================
//  Module   : tb_alu_sequencer
//  Purpose  : Directed, table-driven bench for alu_sequencer.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_sequencer;

    localparam int DATA_W  = 32;
    localparam int OP_W    = 4;
    localparam int SHIFT_W = 5;
    localparam int CNT_W   = 16;

    // ctrl vector bits: bde ibl obl pcu cin fa done busy halted ready
    localparam logic [9:0] C_IDLE = 10'b0000000001;
    localparam logic [9:0] C_DONE = 10'b0000001100;
    localparam logic [9:0] C_HALT = 10'b0000000110;

    logic               clk = 1'b0;
    logic               reset;
    logic               req_valid;
    logic               req_ready;
    logic               req_pc_inc;
    logic [OP_W-1:0]    req_op_code;
    logic [SHIFT_W-1:0] req_shift;
    logic               req_carry_in;
    logic               req_forced_add;
    logic [DATA_W-1:0]  req_operand_a;
    logic [DATA_W-1:0]  req_operand_b;
    logic               alu_error;
    logic               err_clear;
    logic               bus_drive_en;
    logic [DATA_W-1:0]  bus_data;
    logic               input_buffer_load;
    logic               output_buffer_load;
    logic               pc_update_control;
    logic [OP_W-1:0]    op_code;
    logic [SHIFT_W-1:0] shift;
    logic               carry_in;
    logic               forced_add;
    logic               done;
    logic               busy;
    logic               halted;
    logic [CNT_W-1:0]   op_count;

    logic               unused_ready, unused_bde, unused_ibl, unused_obl, unused_pcu;
    logic               unused_cin, unused_fa, unused_done, unused_busy, unused_halted;
    logic [DATA_W-1:0]  unused_bus;
    logic [OP_W-1:0]    unused_op;
    logic [SHIFT_W-1:0] unused_sh;
    logic [3:0]         sm_op_count;

    always #5 clk = ~clk;

    alu_sequencer #(.DATA_W(DATA_W), .OP_W(OP_W), .SHIFT_W(SHIFT_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_pc_inc(req_pc_inc), .req_op_code(req_op_code), .req_shift(req_shift),
        .req_carry_in(req_carry_in), .req_forced_add(req_forced_add),
        .req_operand_a(req_operand_a), .req_operand_b(req_operand_b),
        .alu_error(alu_error), .err_clear(err_clear),
        .bus_drive_en(bus_drive_en), .bus_data(bus_data),
        .input_buffer_load(input_buffer_load), .output_buffer_load(output_buffer_load),
        .pc_update_control(pc_update_control), .op_code(op_code), .shift(shift),
        .carry_in(carry_in), .forced_add(forced_add), .done(done), .busy(busy),
        .halted(halted), .op_count(op_count)
    );

    // Narrow counter copy so the wrap from all-ones to zero is reachable quickly
    alu_sequencer #(.DATA_W(DATA_W), .OP_W(OP_W), .SHIFT_W(SHIFT_W), .CNT_W(4)) dut_w (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(unused_ready),
        .req_pc_inc(req_pc_inc), .req_op_code(req_op_code), .req_shift(req_shift),
        .req_carry_in(req_carry_in), .req_forced_add(req_forced_add),
        .req_operand_a(req_operand_a), .req_operand_b(req_operand_b),
        .alu_error(alu_error), .err_clear(err_clear),
        .bus_drive_en(unused_bde), .bus_data(unused_bus),
        .input_buffer_load(unused_ibl), .output_buffer_load(unused_obl),
        .pc_update_control(unused_pcu), .op_code(unused_op), .shift(unused_sh),
        .carry_in(unused_cin), .forced_add(unused_fa), .done(unused_done),
        .busy(unused_busy), .halted(unused_halted), .op_count(sm_op_count)
    );

    typedef struct {
        logic               pc_inc;
        logic [OP_W-1:0]    op;
        logic [SHIFT_W-1:0] sh;
        logic               cin;
        logic               fa;
        logic [DATA_W-1:0]  a;
        logic [DATA_W-1:0]  b;
        logic               exp_fa;
        int                 exp_lat;
    } vec_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] exp_count;
    vec_t        vecs [5];
    vec_t        pcv;

    wire [9:0] ctrl_act = {bus_drive_en, input_buffer_load, output_buffer_load,
                           pc_update_control, carry_in, forced_add, done, busy,
                           halted, req_ready};

    function automatic logic [9:0] ctrl_exp(input logic bde, input logic ibl,
        input logic obl, input logic pcu, input logic cin, input logic fa,
        input logic dn, input logic bsy, input logic hlt, input logic rdy);
        return {bde, ibl, obl, pcu, cin, fa, dn, bsy, hlt, rdy};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_cycle(input string tag, input logic [9:0] ec,
                               input logic [31:0] eb, input logic [8:0] eo);
        @(negedge clk);
        chk({tag, " ctrl"}, {22'b0, ctrl_act}, {22'b0, ec});
        chk({tag, " bus"}, bus_data, eb);
        chk({tag, " op/shift"}, {23'b0, op_code, shift}, {23'b0, eo});
    endtask

    task automatic drive_req(input vec_t v);
        req_pc_inc     = v.pc_inc;
        req_op_code    = v.op;
        req_shift      = v.sh;
        req_carry_in   = v.cin;
        req_forced_add = v.fa;
        req_operand_a  = v.a;
        req_operand_b  = v.b;
        req_valid      = 1'b1;
    endtask

    task automatic scramble_req(input vec_t v);
        req_pc_inc     = ~v.pc_inc;
        req_op_code    = ~v.op;
        req_shift      = ~v.sh;
        req_carry_in   = ~v.cin;
        req_forced_add = ~v.fa;
        req_operand_a  = ~v.a;
        req_operand_b  = ~v.b;
    endtask

    // Entered and left just after a rising edge with the DUT in IDLE
    task automatic run_vec(input vec_t v, input string tag);
        drive_req(v);
        check_cycle({tag, " idle"}, C_IDLE, 32'h0, 9'h0);
        chk({tag, " count"}, {16'b0, op_count}, {16'b0, exp_count});
        @(posedge clk); #1;
        req_valid = 1'b0;
        scramble_req(v);
        if (v.exp_lat == 3)
            check_cycle({tag, " load_a"}, ctrl_exp(1,1,0,0,0,0,0,1,0,0), v.a, 9'h0);
        check_cycle({tag, " exec"}, ctrl_exp(1,0,1,v.pc_inc,v.cin,v.exp_fa,0,1,0,0),
                    v.b, {v.op, v.sh});
        check_cycle({tag, " done"}, C_DONE, 32'h0, 9'h0);
        @(posedge clk); #1;
        exp_count++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1'b0, 4'h3, 5'd2,  1'b1, 1'b0, 32'h5,        32'h7,        1'b0, 3};
        vecs[1] = '{1'b1, 4'h0, 5'd0,  1'b0, 1'b0, 32'hdead_beef, 32'h100,      1'b1, 2};
        vecs[2] = '{1'b0, 4'hf, 5'd31, 1'b0, 1'b1, 32'hffff_ffff, 32'h0,        1'b1, 3};
        vecs[3] = '{1'b1, 4'h5, 5'd3,  1'b1, 1'b0, 32'h0,        32'h7fff_fffe, 1'b1, 2};
        vecs[4] = '{1'b0, 4'ha, 5'd16, 1'b1, 1'b0, 32'ha5a5_a5a5, 32'h5a5a_5a5a, 1'b0, 3};
        pcv     = '{1'b1, 4'h0, 5'd0,  1'b0, 1'b0, 32'h0,        32'h42,       1'b1, 2};

        reset = 1'b1; req_valid = 1'b0; req_pc_inc = 1'b0; req_op_code = '0;
        req_shift = '0; req_carry_in = 1'b0; req_forced_add = 1'b0;
        req_operand_a = '0; req_operand_b = '0; alu_error = 1'b0; err_clear = 1'b0;
        exp_count = '0;

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check_cycle("reset", C_IDLE, 32'h0, 9'h0);
        chk("reset count", {16'b0, op_count}, 32'h0);

        // Reset during EXEC drops the operation silently
        drive_req(vecs[0]);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check_cycle("rst load_a", ctrl_exp(1,1,0,0,0,0,0,1,0,0), 32'h5, 9'h0);
        check_cycle("rst exec", ctrl_exp(1,0,1,0,1,0,0,1,0,0), 32'h7, {4'h3, 5'd2});
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_cycle("rst idle", C_IDLE, 32'h0, 9'h0);
        chk("rst count", {16'b0, op_count}, 32'h0);
        check_cycle("rst no done", C_IDLE, 32'h0, 9'h0);
        @(posedge clk); #1;

        for (int i = 0; i < 5; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Request held valid with changing fields across a whole operation
        drive_req(vecs[0]);
        check_cycle("hold idle", C_IDLE, 32'h0, 9'h0);
        @(posedge clk); #1;
        drive_req(pcv);
        req_operand_b = 32'h300;
        check_cycle("hold load_a", ctrl_exp(1,1,0,0,0,0,0,1,0,0), 32'h5, 9'h0);
        check_cycle("hold exec", ctrl_exp(1,0,1,0,1,0,0,1,0,0), 32'h7, {4'h3, 5'd2});
        check_cycle("hold done", C_DONE, 32'h0, 9'h0);
        check_cycle("hold idle2", C_IDLE, 32'h0, 9'h0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        exp_count++;
        check_cycle("hold2 exec", ctrl_exp(1,0,1,1,0,1,0,1,0,0), 32'h300, 9'h0);
        check_cycle("hold2 done", C_DONE, 32'h0, 9'h0);
        @(posedge clk); #1;
        exp_count++;

        // Error reported during DONE
        drive_req(pcv);
        alu_error = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check_cycle("err exec", ctrl_exp(1,0,1,1,0,1,0,1,0,0), 32'h42, 9'h0);
        check_cycle("err done", C_DONE, 32'h0, 9'h0);
        @(posedge clk); #1;
        exp_count++;
`ifdef ALU_SEQ_ERR_HALT_EN
        req_valid = 1'b1;
        check_cycle("halt", C_HALT, 32'h0, 9'h0);
        chk("halt count", {16'b0, op_count}, {16'b0, exp_count});
        check_cycle("halt held", C_HALT, 32'h0, 9'h0);
        req_valid = 1'b0;
        err_clear = 1'b1;
        @(posedge clk); #1;
        err_clear = 1'b0;
        alu_error = 1'b0;
        check_cycle("halt cleared", C_IDLE, 32'h0, 9'h0);
`else
        check_cycle("no halt", C_IDLE, 32'h0, 9'h0);
        chk("no halt count", {16'b0, op_count}, {16'b0, exp_count});
        alu_error = 1'b0;
`endif
        @(posedge clk); #1;

        // Counter wrap on the 4-bit copy
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_count = '0;
        for (int i = 0; i < 15; i++) begin
            run_vec(pcv, "wrap");
        end
        @(negedge clk);
        chk("wrap pre", {28'b0, sm_op_count}, 32'hf);
        @(posedge clk); #1;
        run_vec(pcv, "wrap last");
        @(negedge clk);
        chk("wrap zero", {28'b0, sm_op_count}, 32'h0);
        chk("wrap wide", {16'b0, op_count}, 32'd16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
